// File: rtl/spi_slave_param.sv
// Parametrised SPI slave front-end: deserialises {cmd, payload} frames from MOSI,
// hands read data back on MISO after a tx_valid/tx_ready handshake, and flags
// aborted frames or read-data timeouts on frame_err.
module spi_slave_param #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SS_n,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic [DATA_WIDTH+1:0] rx_data,
    output logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  frame_err
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 2);
    localparam int TMO_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] RX_LAST  = CNT_W'(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CMD_BITS = CNT_W'(2);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA,
        TX_WAIT,
        TX_SHIFT
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [1:0]              cmd_q, cmd_d;
    logic [DATA_WIDTH-1:0]   pay_q, pay_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d;
    logic [DATA_WIDTH+1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    rd_seen_q, rd_seen_d;
    logic [DATA_WIDTH-1:0]   pay_shift;
    logic [DATA_WIDTH-1:0]   tx_shift;

    // State register and all datapath registers; async reset returns everything to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            cmd_q       <= '0;
            pay_q       <= '0;
            tx_q        <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rd_seen_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            cmd_q       <= cmd_d;
            pay_q       <= pay_d;
            tx_q        <= tx_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            rd_seen_q   <= rd_seen_d;
        end
    end

    // Next-state logic: frame sequencing, bit shifting, handshake, timeout and abort.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        cmd_d       = cmd_q;
        pay_d       = pay_q;
        tx_d        = tx_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        rd_seen_d   = rd_seen_q;
        pay_shift   = MSB_FIRST ? {pay_q[DATA_WIDTH-2:0], MOSI} : {MOSI, pay_q[DATA_WIDTH-1:1]};
        tx_shift    = MSB_FIRST ? {tx_q[DATA_WIDTH-2:0], 1'b0} : {1'b0, tx_q[DATA_WIDTH-1:1]};

        case (state_q)
            IDLE: begin
                if (!SS_n) begin
                    state_d = CHK_CMD;
                end
            end

            CHK_CMD: begin
                cnt_d = '0;
                if (SS_n) begin
                    state_d = IDLE;
                end else if (!MOSI) begin
                    state_d = WRITE;
                end else if (rd_seen_q) begin
                    state_d = READ_DATA;
                end else begin
                    state_d = READ_ADD;
                end
            end

            WRITE, READ_ADD, READ_DATA: begin
                if (cnt_q == RX_LAST) begin
                    rx_data_d  = {cmd_q, pay_shift};
                    rx_valid_d = 1'b1;
                    cnt_d      = '0;
                    if (state_q == READ_DATA) begin
                        state_d   = TX_WAIT;
                        rd_seen_d = 1'b0;
                        tmo_d     = '0;
                    end else begin
                        state_d = IDLE;
                        if (state_q == READ_ADD) begin
                            rd_seen_d = 1'b1;
                        end
                    end
                end else if (SS_n) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else begin
                    if (cnt_q < CMD_BITS) begin
                        cmd_d = {cmd_q[0], MOSI};
                    end else begin
                        pay_d = pay_shift;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            TX_WAIT: begin
                if (SS_n) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    tmo_d       = '0;
                end else if (tx_valid) begin
                    tx_d    = tx_data;
                    state_d = TX_SHIFT;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    tmo_d       = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            TX_SHIFT: begin
                if (SS_n) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    tx_d        = '0;
                    cnt_d       = '0;
                end else if (cnt_q == TX_LAST) begin
                    state_d = IDLE;
                    tx_d    = '0;
                    cnt_d   = '0;
                end else begin
                    tx_d  = tx_shift;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign MISO      = (state_q == TX_SHIFT) && (MSB_FIRST ? tx_q[DATA_WIDTH-1] : tx_q[0]);
    assign tx_ready  = (state_q == TX_WAIT);
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Self-checking bench: a frame-level model plans every cycle's inputs and expected
// outputs; one negedge process compares two DUT configurations (8-bit MSB-first and
// 16-bit LSB-first) against it, plus literal checks taken from hand-worked examples.
`timescale 1ns/1ps
module tb_spi_slave_param;

    localparam int RD_TIMEOUT = 16;

    typedef struct {
        logic        ssn;
        logic        mosi;
        logic        txv;
        logic [15:0] txd;
        logic        miso;
        logic        rxv;
        logic [17:0] rxd;
        logic        txr;
        logic        ferr;
    } cycle_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        SS_n;
    logic        MOSI;
    logic        tx_valid;
    logic [15:0] txData;

    logic        misoA, rxValidA, txReadyA, frameErrA;
    logic [9:0]  rxDataA;
    logic        misoB, rxValidB, txReadyB, frameErrB;
    logic [17:0] rxDataB;

    // Model state and expectations
    int          W = 8;
    logic        msb = 1'b1;
    logic        cfgSel = 1'b0;
    logic        mRdSeen = 1'b0;
    logic [17:0] mRxData = '0;
    cycle_t      plan[$];

    logic        checkEn = 1'b0;
    logic        expMiso = 1'b0, expRxv = 1'b0, expTxr = 1'b0, expFerr = 1'b0;
    logic [17:0] expRxd = '0;

    int          errors = 0;
    int          checks = 0;

    int          rxvCount, txrCount, ferrCount, misoOnes, misoIdx;
    logic        misoStarted;
    logic [15:0] misoSeq;
    logic [17:0] lastRx;

    logic        actMiso, actRxv, actTxr, actFerr;
    logic [17:0] actRxd;

    always #5 clk = ~clk;

    spi_slave_param #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .RD_TIMEOUT(RD_TIMEOUT)) dutA (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(misoA),
        .rx_data(rxDataA), .rx_valid(rxValidA), .tx_data(txData[7:0]),
        .tx_valid(tx_valid), .tx_ready(txReadyA), .frame_err(frameErrA)
    );

    spi_slave_param #(.DATA_WIDTH(16), .MSB_FIRST(1'b0), .RD_TIMEOUT(RD_TIMEOUT)) dutB (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(misoB),
        .rx_data(rxDataB), .rx_valid(rxValidB), .tx_data(txData),
        .tx_valid(tx_valid), .tx_ready(txReadyB), .frame_err(frameErrB)
    );

    // Select which configuration is under check
    always_comb begin
        actMiso = cfgSel ? misoB     : misoA;
        actRxv  = cfgSel ? rxValidB  : rxValidA;
        actTxr  = cfgSel ? txReadyB  : txReadyA;
        actFerr = cfgSel ? frameErrB : frameErrA;
        actRxd  = cfgSel ? rxDataB   : {8'd0, rxDataA};
    end

    task automatic checkOutput(input string name, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Compare process: checks every output against the model each cycle and keeps logs
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("miso",      18'(actMiso), 18'(expMiso));
            checkOutput("rx_valid",  18'(actRxv),  18'(expRxv));
            checkOutput("rx_data",   actRxd,       expRxd);
            checkOutput("tx_ready",  18'(actTxr),  18'(expTxr));
            checkOutput("frame_err", 18'(actFerr), 18'(expFerr));
            if (actRxv)  begin rxvCount++; lastRx = actRxd; end
            if (actTxr)  txrCount++;
            if (actFerr) ferrCount++;
            if (actMiso) misoOnes++;
            if ((misoStarted || actMiso) && misoIdx < W) begin
                misoStarted = 1'b1;
                misoSeq = {misoSeq[14:0], actMiso};
                misoIdx++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [15:0] rword();
        return 16'($urandom);
    endfunction

    function automatic logic ssnAt(input int e, input int abortEdge);
        return (abortEdge > 0) && (e >= abortEdge);
    endfunction

    function automatic logic txBit(input logic [15:0] w, input int i);
        return msb ? w[W-1-i] : w[i];
    endfunction

    task automatic clearLogs();
        rxvCount = 0; txrCount = 0; ferrCount = 0; misoOnes = 0; misoIdx = 0;
        misoStarted = 1'b0; misoSeq = '0; lastRx = '0;
    endtask

    task automatic addCycle(input logic ssn, input logic mosi, input logic txv, input logic [15:0] txd,
                            input logic miso, input logic rxv, input logic txr, input logic ferr);
        cycle_t c;
        c.ssn = ssn; c.mosi = mosi; c.txv = txv; c.txd = txd;
        c.miso = miso; c.rxv = rxv; c.rxd = mRxData; c.txr = txr; c.ferr = ferr;
        plan.push_back(c);
    endtask

    task automatic planGap(input int n);
        for (int i = 0; i < n; i++) addCycle(1'b1, rbit(), rbit(), rword(), 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One frame as the master sees it; abortEdge is the frame edge where SS_n goes high
    task automatic planFrame(input int abortEdge, input logic typeBit, input logic [1:0] cmd,
                             input logic [15:0] pay, input int txDelay, input logic [15:0] txw);
        int          e;
        logic        isReadData;
        logic        b;
        logic [17:0] word;
        addCycle(1'b0, rbit(), rbit(), rword(), 1'b0, 1'b0, 1'b0, 1'b0);
        e = 1;
        if (ssnAt(e, abortEdge)) begin
            addCycle(1'b1, rbit(), rbit(), rword(), 1'b0, 1'b0, 1'b0, 1'b0);
            return;
        end
        addCycle(1'b0, typeBit, rbit(), rword(), 1'b0, 1'b0, 1'b0, 1'b0);
        isReadData = typeBit && mRdSeen;
        word = (18'(cmd) << W) | (18'(pay) & ((18'd1 << W) - 18'd1));
        for (int j = 0; j < W + 2; j++) begin
            e++;
            if (j == 0)      b = cmd[1];
            else if (j == 1) b = cmd[0];
            else if (msb)    b = pay[W-1-(j-2)];
            else             b = pay[j-2];
            if (j < W + 1) begin
                if (ssnAt(e, abortEdge)) begin
                    addCycle(1'b1, rbit(), rbit(), rword(), 1'b0, 1'b0, 1'b0, 1'b1);
                    return;
                end
                addCycle(1'b0, b, rbit(), rword(), 1'b0, 1'b0, 1'b0, 1'b0);
            end else begin
                mRxData = word;
                if (typeBit) mRdSeen = !isReadData;
                addCycle(ssnAt(e, abortEdge), b, rbit(), rword(), 1'b0, 1'b1, isReadData, 1'b0);
            end
        end
        if (!isReadData) return;
        for (int k = 0; k < RD_TIMEOUT; k++) begin
            e++;
            if (ssnAt(e, abortEdge)) begin
                addCycle(1'b1, rbit(), rbit(), rword(), 1'b0, 1'b0, 1'b0, 1'b1);
                return;
            end
            if (k == txDelay) begin
                addCycle(1'b0, rbit(), 1'b1, txw, txBit(txw, 0), 1'b0, 1'b0, 1'b0);
                break;
            end
            if (k == RD_TIMEOUT - 1) begin
                addCycle(1'b0, rbit(), 1'b0, rword(), 1'b0, 1'b0, 1'b0, 1'b1);
                return;
            end
            addCycle(1'b0, rbit(), 1'b0, rword(), 1'b0, 1'b0, 1'b1, 1'b0);
        end
        for (int s = 0; s < W; s++) begin
            e++;
            if (ssnAt(e, abortEdge)) begin
                addCycle(1'b1, rbit(), rbit(), rword(), 1'b0, 1'b0, 1'b0, 1'b1);
                return;
            end
            if (s == W - 1) addCycle(1'b0, rbit(), rbit(), rword(), 1'b0, 1'b0, 1'b0, 1'b0);
            else            addCycle(1'b0, rbit(), rbit(), rword(), txBit(txw, s + 1), 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic applyStimulus(input int maxN);
        cycle_t c;
        int     n;
        n = 0;
        while (plan.size() > 0 && n < maxN) begin
            c = plan.pop_front();
            SS_n = c.ssn; MOSI = c.mosi; tx_valid = c.txv; txData = c.txd;
            @(posedge clk);
            expMiso = c.miso; expRxv = c.rxv; expRxd = c.rxd; expTxr = c.txr; expFerr = c.ferr;
            #1;
            n++;
        end
    endtask

    task automatic resetModel();
        plan.delete();
        mRdSeen = 1'b0; mRxData = '0;
        expMiso = 1'b0; expRxv = 1'b0; expRxd = '0; expTxr = 1'b0; expFerr = 1'b0;
    endtask

    task automatic resetDut();
        checkEn = 1'b0;
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; txData = '0;
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_miso",      18'(actMiso), 18'd0);
        checkOutput("reset_rx_valid",  18'(actRxv),  18'd0);
        checkOutput("reset_rx_data",   actRxd,       18'd0);
        checkOutput("reset_tx_ready",  18'(actTxr),  18'd0);
        checkOutput("reset_frame_err", 18'(actFerr), 18'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 checkEn = 1'b1;
    endtask

    task automatic randomFrames(input int n);
        for (int i = 0; i < n; i++) begin
            int ab;
            int td;
            int len;
            len = 4 + W + RD_TIMEOUT + W;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len)) : -1;
            td = ($urandom_range(0, 4) == 0) ? RD_TIMEOUT + 2 : int'($urandom_range(0, 4));
            planFrame(ab, rbit(), 2'($urandom), rword(), td, rword());
            planGap(int'($urandom_range(0, 2)));
        end
        planGap(2);
        applyStimulus(100000);
    endtask

    initial begin
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; txData = '0;
        clearLogs();
        cfgSel = 1'b0; W = 8; msb = 1'b1;
        resetDut();

        // Write 00 + A5
        clearLogs();
        planFrame(-1, 1'b0, 2'b00, 16'h00A5, 0, 16'h0); planGap(2); applyStimulus(1000);
        checkOutput("t1_rx_count", 18'(rxvCount), 18'd1);
        checkOutput("t1_rx_data",  lastRx,        18'h0A5);
        checkOutput("t1_miso_low", 18'(misoOnes), 18'd0);

        // Read-address then read-data returning 0x96
        clearLogs();
        planFrame(-1, 1'b1, 2'b10, 16'h003C, 0, 16'h0); planGap(1); applyStimulus(1000);
        checkOutput("t2_addr_data",  lastRx,        18'h23C);
        checkOutput("t2_addr_no_tx", 18'(txrCount), 18'd0);
        clearLogs();
        planFrame(-1, 1'b1, 2'b11, 16'h0000, 0, 16'h0096); planGap(2); applyStimulus(1000);
        checkOutput("t2_rd_data",  lastRx,        18'h300);
        checkOutput("t2_tx_ready", 18'(txrCount), 18'd1);
        checkOutput("t2_miso_seq", 18'(misoSeq),  18'h096);

        // Read-data timeout
        planFrame(-1, 1'b1, 2'b10, 16'h0011, 0, 16'h0); planGap(1); applyStimulus(1000);
        clearLogs();
        planFrame(-1, 1'b1, 2'b11, 16'h0022, RD_TIMEOUT + 5, 16'hFFFF); planGap(2); applyStimulus(1000);
        checkOutput("t4_tx_ready_cycles", 18'(txrCount),  18'd16);
        checkOutput("t4_frame_err",       18'(ferrCount), 18'd1);
        checkOutput("t4_miso_low",        18'(misoOnes),  18'd0);

        // Abort after 5 of 10 write bits, then a clean frame
        planFrame(-1, 1'b0, 2'b00, 16'h005A, 0, 16'h0); planGap(1); applyStimulus(1000);
        clearLogs();
        planFrame(7, 1'b0, 2'b01, 16'h00FF, 0, 16'h0); planGap(2); applyStimulus(1000);
        checkOutput("t5_frame_err", 18'(ferrCount), 18'd1);
        checkOutput("t5_no_rx",     18'(rxvCount),  18'd0);
        checkOutput("t5_rx_held",   actRxd,         18'h05A);
        clearLogs();
        planFrame(-1, 1'b0, 2'b01, 16'h00C3, 0, 16'h0); planGap(2); applyStimulus(1000);
        checkOutput("t5_next_frame", lastRx, 18'h1C3);

        // Abort in CHK_CMD is silent; SS_n rise on the last bit still completes
        clearLogs();
        planFrame(1, 1'b1, 2'b11, 16'h0000, 0, 16'h0); planGap(2); applyStimulus(1000);
        checkOutput("chk_abort_no_err", 18'(ferrCount), 18'd0);
        clearLogs();
        planFrame(11, 1'b0, 2'b10, 16'h0081, 0, 16'h0); planGap(2); applyStimulus(1000);
        checkOutput("simul_rx_count", 18'(rxvCount),  18'd1);
        checkOutput("simul_no_err",   18'(ferrCount), 18'd0);
        checkOutput("simul_rx_data",  lastRx,         18'h281);

        // Async reset in the middle of TX_SHIFT
        planFrame(-1, 1'b1, 2'b10, 16'h0001, 0, 16'h0);
        planFrame(-1, 1'b1, 2'b11, 16'h0002, 0, 16'h00FF);
        applyStimulus(27);
        @(negedge clk); #1;
        checkOutput("t6_pre_miso", 18'(actMiso), 18'd1);
        checkEn = 1'b0;
        rst_n = 1'b0; SS_n = 1'b1;
        #1;
        checkOutput("t6_miso",     18'(actMiso), 18'd0);
        checkOutput("t6_tx_ready", 18'(actTxr),  18'd0);
        checkOutput("t6_rx_valid", 18'(actRxv),  18'd0);
        resetModel();
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1 checkEn = 1'b1;
        clearLogs();
        planFrame(-1, 1'b1, 2'b10, 16'h0011, 0, 16'hFFFF); planGap(2); applyStimulus(1000);
        checkOutput("t6_read_add_no_tx", 18'(txrCount), 18'd0);
        checkOutput("t6_read_add_data",  lastRx,        18'h211);

        randomFrames(60);

        // 16-bit LSB-first configuration
        cfgSel = 1'b1; W = 16; msb = 1'b0;
        resetDut();
        clearLogs();
        planFrame(-1, 1'b0, 2'b00, 16'h8001, 0, 16'h0); planGap(2); applyStimulus(1000);
        checkOutput("t3_rx_data", lastRx, 18'h08001);
        planFrame(-1, 1'b1, 2'b10, 16'h1234, 0, 16'h0); planGap(1); applyStimulus(1000);
        clearLogs();
        planFrame(-1, 1'b1, 2'b11, 16'h0000, 2, 16'h0003); planGap(2); applyStimulus(1000);
        checkOutput("t3_miso_seq",   18'(misoSeq),  18'h0C000);
        checkOutput("t3_miso_count", 18'(misoOnes), 18'd2);

        randomFrames(30);

        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
